// File: rtl/mips_pkg.sv
// mips_pkg: op codes, FSM states and default width shared by the MIPS multiply/divide unit.
// The DIV state exists only when MIPS_MDU_DIV_EN is defined.
package mips_pkg;
  localparam int MDU_WIDTH = 32;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
`ifdef MIPS_MDU_DIV_EN
    S_DIV,
`endif
    S_FIX,
    S_DONE
  } mdu_state_e;
endpackage

// File: rtl/mdu_cond_negate.sv
// mdu_cond_negate: two's-complement negate of in_i when neg_i is set, pass-through otherwise.
module mdu_cond_negate #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);
  assign out_o = neg_i ? -in_i : in_i;
endmodule

// File: rtl/mips_mult_div_unit.sv
// mips_mult_div_unit: iterative MIPS HI/LO unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO), WIDTH cycles per op.
// Define MIPS_MDU_DIV_EN to build the restoring divider; without it DIV/DIVU only flag div0.
module mips_mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod_fix;
  logic [WIDTH-1:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b;
  logic neg_q, neg_d, div0_q, div0_d;
  logic is_signed, sa, sb, accept, last;
  logic [WIDTH:0] mul_sum;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sa = is_signed & a[WIDTH-1];
  assign sb = is_signed & b[WIDTH-1];
  assign accept = start && !flush && (op <= OP_MTLO) && (state_q == S_IDLE || state_q == S_DONE);
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);

  mdu_cond_negate #(.W(WIDTH)) u_abs_a (.neg_i(sa), .in_i(a), .out_o(abs_a));
  mdu_cond_negate #(.W(WIDTH)) u_abs_b (.neg_i(sb), .in_i(b), .out_o(abs_b));
  mdu_cond_negate #(.W(2*WIDTH)) u_fix_prod (.neg_i(neg_q), .in_i(acc_q), .out_o(prod_fix));

`ifdef MIPS_MDU_DIV_EN
  logic rneg_q, rneg_d, isdiv_q, isdiv_d, bz_q, bz_d, div_ge;
  logic [WIDTH:0] div_trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  // acc holds {partial remainder, remaining dividend bits / quotient bits}
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
  assign div_ge = !div_trial[WIDTH];
  mdu_cond_negate #(.W(WIDTH)) u_fix_quo (.neg_i(neg_q), .in_i(acc_q[WIDTH-1:0]), .out_o(quo_fix));
  mdu_cond_negate #(.W(WIDTH)) u_fix_rem (.neg_i(rneg_q), .in_i(acc_q[2*WIDTH-1:WIDTH]), .out_o(rem_fix));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      neg_q <= 1'b0;
      div0_q <= 1'b0;
`ifdef MIPS_MDU_DIV_EN
      rneg_q <= 1'b0;
      isdiv_q <= 1'b0;
      bz_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opd_q <= opd_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      neg_q <= neg_d;
      div0_q <= div0_d;
`ifdef MIPS_MDU_DIV_EN
      rneg_q <= rneg_d;
      isdiv_q <= isdiv_d;
      bz_q <= bz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opd_d = opd_q;
    hi_d = hi_q;
    lo_d = lo_q;
    neg_d = neg_q;
    div0_d = div0_q;
`ifdef MIPS_MDU_DIV_EN
    rneg_d = rneg_q;
    isdiv_d = isdiv_q;
    bz_d = bz_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
    end else if (accept) begin
      cnt_d = '0;
      neg_d = sa ^ sb;
      opd_d = abs_b;
      acc_d = {{WIDTH{1'b0}}, abs_a};
`ifdef MIPS_MDU_DIV_EN
      rneg_d = sa;
      isdiv_d = (op == OP_DIV) || (op == OP_DIVU);
      bz_d = b == '0;
`endif
      if (op == OP_MTHI) begin
        hi_d = a;
        div0_d = 1'b0;
        state_d = S_DONE;
      end else if (op == OP_MTLO) begin
        lo_d = a;
        div0_d = 1'b0;
        state_d = S_DONE;
      end else if (op == OP_MULT || op == OP_MULTU) begin
        state_d = S_MUL;
      end else begin
`ifdef MIPS_MDU_DIV_EN
        state_d = S_DIV;
`else
        div0_d = 1'b1;
        state_d = S_DONE;
`endif
      end
    end else if (state_q == S_MUL) begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      state_d = last ? S_FIX : S_MUL;
`ifdef MIPS_MDU_DIV_EN
    end else if (state_q == S_DIV) begin
      acc_d = {div_ge ? div_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], div_ge};
      cnt_d = cnt_q + CNT_W'(1);
      state_d = last ? S_FIX : S_DIV;
`endif
    end else if (state_q == S_FIX) begin
      {hi_d, lo_d} = prod_fix;
      div0_d = 1'b0;
`ifdef MIPS_MDU_DIV_EN
      if (isdiv_q) begin
        hi_d = rem_fix;
        lo_d = bz_q ? '1 : quo_fix;
        div0_d = bz_q;
      end
`endif
      state_d = S_DONE;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  assign busy = !(state_q == S_IDLE || state_q == S_DONE);
  assign done = state_q == S_DONE;
  assign div0 = div0_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mips_mult_div_unit.sv
// tb_mips_mult_div_unit: table-driven scoreboard bench for mips_mult_div_unit (WIDTH=32),
// with expectations for both MIPS_MDU_DIV_EN builds.
module tb_mips_mult_div_unit;
  import mips_pkg::*;
  localparam int W = 32;
`ifdef MIPS_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } vec_t;
  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           lat;
    int           busy;
  } exp_t;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div0;
  logic [W-1:0] hi, lo;
  logic [W-1:0] mdl_hi = '0, mdl_lo = '0;
  int tests = 0, fails = 0, cyc = 0, e0 = 0;
  exp_t sb_q[$];
  vec_t vt[14];

  mips_mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    logic dv, skip;
    dv = (v.op == OP_DIV) || (v.op == OP_DIVU);
    skip = dv && !DIV_EN;
    e.hi = (v.op == OP_MTLO || skip) ? mdl_hi : v.hi;
    e.lo = (v.op == OP_MTHI || skip) ? mdl_lo : v.lo;
    e.div0 = skip ? 1'b1 : v.div0;
    e.lat = (v.op <= OP_DIVU && !skip) ? W + 2 : 1;
    e.busy = (v.op <= OP_DIVU && !skip) ? W + 1 : 0;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic collect(input int intrude);
    exp_t e;
    int n, bc;
    logic held;
    e = sb_q.pop_front();
    bc = 0;
    held = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n = cyc - e0 + 1;
      if (intrude > 0 && n == intrude) begin
        op = OP_MULT;
        a = 2;
        b = 2;
        start = 1'b1;
      end
      if (intrude > 0 && n == intrude + 1) start = 1'b0;
      if (busy) bc++;
      if (!done && (hi !== mdl_hi || lo !== mdl_lo)) held = 1'b0;
    end while (!done && n < 200);
    chk("done_seen", 64'(done), 64'(1));
    chk("latency", 64'(n), 64'(e.lat));
    chk("busy_cycles", 64'(bc), 64'(e.busy));
    chk("hilo_hold", 64'(held), 64'(1));
    chk("hi", 64'(hi), 64'(e.hi));
    chk("lo", 64'(lo), 64'(e.lo));
    chk("div0", 64'(div0), 64'(e.div0));
    mdl_hi = e.hi;
    mdl_lo = e.lo;
  endtask

  task automatic watch(input int k, output int dn, output int bz);
    dn = 0;
    bz = 0;
    repeat (k) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int dn, bz;
    vt[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vt[1]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vt[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3]  = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vt[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[6]  = '{OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0};
    vt[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vt[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vt[9]  = '{OP_MTLO,  32'hCAFEBABE, 32'h00000000, 32'h00000000, 32'hCAFEBABE, 1'b0};
    vt[10] = '{OP_MTHI,  32'h0BADF00D, 32'h00000000, 32'h0BADF00D, 32'h00000000, 1'b0};
    vt[11] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vt[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vt[13] = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
    #3;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div0", 64'(div0), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // consecutive vectors start in the previous DONE cycle (back-to-back)
    for (int i = 0; i < 14; i++) begin
      push(vt[i]);
      issue(vt[i].op, vt[i].a, vt[i].b);
      collect(0);
    end
    // start while busy is ignored
    push('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    collect(5);
    watch(W + 5, dn, bz);
    chk("ignored_start_done", 64'(dn), 64'(0));
    chk("ignored_start_busy", 64'(bz), 64'(0));
    // flush mid-operation
    push('{OP_MTHI, 32'h12345678, 32'h0, 32'h12345678, 32'h0, 1'b0});
    issue(OP_MTHI, 32'h12345678, 32'h0);
    collect(0);
    issue(DIV_EN ? OP_DIVU : OP_MULTU, 32'd9, 32'd3);
    repeat (10) @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'(0));
    watch(W + 5, dn, bz);
    chk("flush_no_done", 64'(dn), 64'(0));
    chk("flush_hi", 64'(hi), 64'(32'h12345678));
    chk("flush_lo", 64'(lo), 64'(mdl_lo));
    // undefined op codes do nothing
    op = 3'd6;
    start = 1'b1;
    watch(2, dn, bz);
    op = 3'd7;
    watch(2, dn, bz);
    start = 1'b0;
    watch(2, dn, bz);
    chk("undef_done", 64'(dn), 64'(0));
    chk("undef_busy", 64'(bz), 64'(0));
    chk("undef_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    // asynchronous reset mid-operation
    issue(OP_MULT, 32'd11, 32'd13);
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_div0", 64'(div0), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
    push('{OP_MULTU, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b0});
    issue(OP_MULTU, 32'd6, 32'd7);
    collect(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
